fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset is synchronous and active-low.
REQ-004 Port: stall  in  1  hazard unit holds the F/D register; no new instruction accepted.
REQ-005 Port: branch_taken  in  1  decode resolved a taken branch this cycle.
REQ-006 Port: branch_target  in  16  redirect address, valid with branch_taken.
REQ-007 Port: imem_req  out  1  read request to instruction memory, one cycle per request.
REQ-008 Port: imem_addr  out  16  request address, valid with imem_req.
REQ-009 Port: imem_valid  in  1  response strobe, at least 1 cycle after imem_req, in order.
REQ-010 Port: imem_data  in  16  instruction word, valid with imem_valid.
REQ-011 Port: instr_out  out  16  instruction presented to the F/D register.
REQ-012 Port: oldPC_out  out  16  address of instr_out.
REQ-013 Port: newPC_out  out  16  oldPC_out + 2.
REQ-014 Port: fd_wen  out  1  F/D register write enable.
REQ-015 Port: fd_flush  out  1  F/D register loads a NOP this cycle.
REQ-016 Port: halted  out  1  HALT fetched; fetching stopped.

Function
REQ-017 States: FETCH, WAIT, HOLD, HALT.
REQ-018 FETCH: imem_req=1, imem_addr=pc; next state WAIT.
REQ-019 At most one request outstanding; imem_req=0 in WAIT, HOLD and HALT.
REQ-020 WAIT, imem_valid=1, stall=0: fd_wen=1 same cycle; instr_out=imem_data, oldPC_out=pc, newPC_out=pc+2; pc<=pc+2; next FETCH (HALT if imem_data[15:12]==4'hF).
REQ-021 WAIT, imem_valid=1, stall=1: imem_data and pc captured in hold buffer; next HOLD; fd_wen=0.
REQ-022 HOLD: outputs driven from hold buffer; fd_wen=!stall; on fd_wen, pc<=pc+2 and next FETCH (HALT if buffered opcode 4'hF).
REQ-023 The min issue-to-issue interval is 2 cycles (FETCH, then WAIT with immediate response).
REQ-024 branch_taken=1 in any state: pc<=branch_target; fd_flush=1; fd_wen=0; hold buffer discarded; next FETCH.
REQ-025 branch_taken has priority over stall and over a same-cycle imem_valid.
REQ-026 branch_taken while a request is outstanding sets squash flag; the next imem_valid is discarded with no fd_wen and no state change other than clearing squash.
REQ-027 Redirect from WAIT with request outstanding: next state WAIT-for-squash, then FETCH to branch_target after the discarded response.
REQ-028 HALT: halted=1, no requests, fd_wen=0; exits only on branch_taken (wrong-path halt) or reset.
REQ-029 PC arithmetic is 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000 with no error.
REQ-030 fd_wen and fd_flush never both 1.

Reset
REQ-031 While rst=0 at a clock edge: state=FETCH, pc=RESET_PC, squash=0, hold buffer cleared.
REQ-032 Outputs under reset: imem_req=0, fd_wen=0, fd_flush=0, halted=0, instr_out/oldPC_out/newPC_out=0.
REQ-033 Instruction memory is reset by the same rst; responses in flight at reset are not expected.
REQ-034 First request issues in the first cycle after rst returns to 1, at RESET_PC.

Structure
REQ-035 Shared package fetch_pkg: state enum, HALT_OPCODE=4'hF, PC_INCR=16'd2, NOP_INSTR.
REQ-036 No sub-module; pc, squash, state and hold buffer are plain flops in fetch_unit.

Verification
REQ-037 Reset, memory latency 1, words 16'h1234,16'h5678 at 0,2 -> fd_wen pulses with oldPC 0/newPC 2, then oldPC 2/newPC 4.
REQ-038 Response arrives with stall=1 for 3 cycles -> fd_wen=0, instr_out held stable, single fd_wen on stall release, no extra imem_req.
REQ-039 branch_taken to 16'h0040 while request to 16'h0006 outstanding -> fd_flush=1 one cycle, response for 0006 discarded, next imem_addr=16'h0040.
REQ-040 Fetch 16'hF000 at 16'h0008 -> delivered once, halted=1, imem_req stays 0 for 20 cycles; branch_taken to 16'h0010 -> fetch resumes at 0010.
REQ-041 RESET_PC=16'hFFFE -> first oldPC_out=16'hFFFE, newPC_out=16'h0000, next request at 16'h0000.
REQ-042 rst=0 asserted in HOLD -> next cycle all outputs 0, following request at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM state encoding
//   PC_W          : program counter / address / instruction width
//   HALT_OPCODE   : opcode field value that stops fetching
//   PC_INCR       : byte distance between consecutive instructions
//   NOP_INSTR     : word presented to the F/D register when nothing is delivered
//   is_halt()     : opcode decode for the halt instruction
package fetch_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [3:0]      HALT_OPCODE = 4'hF;
    localparam logic [PC_W-1:0] PC_INCR     = 16'd2;
    localparam logic [PC_W-1:0] NOP_INSTR   = 16'h0000;

    function automatic logic is_halt(input logic [PC_W-1:0] instr);
        return instr[15:12] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if -- instruction memory read channel.
//   imem_req   : one-cycle read request (fetch unit -> memory)
//   imem_addr  : request address, valid with imem_req
//   imem_valid : in-order response strobe (memory -> fetch unit)
//   imem_data  : instruction word, valid with imem_valid
// Modports: master = fetch unit side, slave = memory side.
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [PC_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding-request instruction fetch stage.
//   clk           : clock, all state changes on the rising edge
//   rst           : synchronous, active-low reset
//   stall         : hazard unit holds the F/D register
//   branch_taken  : taken branch resolved in decode this cycle
//   branch_target : redirect address, valid with branch_taken
//   imem          : instruction memory channel (fetch_if.master)
//   instr_out     : instruction presented to the F/D register
//   oldPC_out     : address of instr_out
//   newPC_out     : oldPC_out + 2
//   fd_wen        : F/D register write enable
//   fd_flush      : F/D register loads a NOP
//   halted        : halt instruction fetched, fetching stopped
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    fetch_if.master         imem,
    output logic [PC_W-1:0] instr_out,
    output logic [PC_W-1:0] oldPC_out,
    output logic [PC_W-1:0] newPC_out,
    output logic            fd_wen,
    output logic            fd_flush,
    output logic            halted
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic            squash;
    logic [PC_W-1:0] hold_instr;
    logic [PC_W-1:0] hold_pc;

    // A response is usable only when it is not the one owed to a redirected request.
    logic resp_live;
    assign resp_live = (state == WAIT) && imem.imem_valid && !squash;

    // Output decode: delivery happens in the same cycle as the response, so the
    // F/D-side outputs follow the current state and inputs. Everything is forced
    // to zero while rst is low.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = '0;
        instr_out      = NOP_INSTR;
        oldPC_out      = '0;
        newPC_out      = '0;
        fd_wen         = 1'b0;
        fd_flush       = 1'b0;
        halted         = 1'b0;
        if (rst) begin
            imem.imem_req = (state == FETCH);
            if (state == FETCH) begin
                imem.imem_addr = pc;
            end
            halted = (state == HALT);
            if (branch_taken) begin
                fd_flush = 1'b1;
            end else if (resp_live) begin
                instr_out = imem.imem_data;
                oldPC_out = pc;
                newPC_out = pc + PC_INCR;
                fd_wen    = !stall;
            end else if (state == HOLD) begin
                instr_out = hold_instr;
                oldPC_out = hold_pc;
                newPC_out = hold_pc + PC_INCR;
                fd_wen    = !stall;
            end
        end
    end

    // State, pc, squash flag and hold buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            squash     <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (branch_taken) begin
            pc         <= branch_target;
            hold_instr <= '0;
            hold_pc    <= '0;
            case (state)
                // The request issued this cycle is in flight: wait it out and drop it.
                FETCH: begin
                    state  <= WAIT;
                    squash <= 1'b1;
                end
                // Still owed a response unless it is arriving right now.
                WAIT: begin
                    if (imem.imem_valid) begin
                        state  <= FETCH;
                        squash <= 1'b0;
                    end else begin
                        state  <= WAIT;
                        squash <= 1'b1;
                    end
                end
                default: begin
                    state  <= FETCH;
                    squash <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (imem.imem_valid) begin
                        if (squash) begin
                            squash <= 1'b0;
                            state  <= FETCH;
                        end else if (stall) begin
                            hold_instr <= imem.imem_data;
                            hold_pc    <= pc;
                            state      <= HOLD;
                        end else begin
                            pc    <= pc + PC_INCR;
                            state <= is_halt(imem.imem_data) ? HALT : FETCH;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc    <= pc + PC_INCR;
                        state <= is_halt(hold_instr) ? HALT : FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;

    fetch_if m0 ();
    fetch_if m1 ();

    logic [15:0] instr0, old0, new0, instr1, old1, new1;
    logic        wen0, flush0, hlt0, wen1, flush1, hlt1;

    fetch_unit #(.RESET_PC(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem(m0),
        .instr_out(instr0), .oldPC_out(old0), .newPC_out(new0),
        .fd_wen(wen0), .fd_flush(flush0), .halted(hlt0)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem(m1),
        .instr_out(instr1), .oldPC_out(old1), .newPC_out(new1),
        .fd_wen(wen1), .fd_flush(flush1), .halted(hlt1)
    );

    always #5 clk = ~clk;

    // Packed view: {req, addr, wen, flush, halted, instr, oldpc, newpc}
    logic [67:0] out0, out1;
    assign out0 = {m0.imem_req, m0.imem_addr, wen0, flush0, hlt0, instr0, old0, new0};
    assign out1 = {m1.imem_req, m1.imem_addr, wen1, flush1, hlt1, instr1, old1, new1};

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        iv;
        logic [15:0] idata;
        logic        req;
        logic [15:0] addr;
        logic        wen;
        logic        flush;
        logic        hlt;
        logic [15:0] instr;
        logic [15:0] oldpc;
        logic [15:0] newpc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(
        input logic r, input logic s, input logic b, input logic [15:0] t,
        input logic iv, input logic [15:0] d,
        input logic q, input logic [15:0] a, input logic w, input logic f, input logic h,
        input logic [15:0] ins, input logic [15:0] op, input logic [15:0] np);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.iv = iv; v.idata = d;
        v.req = q; v.addr = a; v.wen = w; v.flush = f; v.hlt = h;
        v.instr = ins; v.oldpc = op; v.newpc = np;
        return v;
    endfunction

    // One clock: drive after the rising edge, compare on the falling edge.
    task automatic apply(input vec_t v, input int sel, input string name);
        logic [67:0] exp_v, act_v;
        @(posedge clk);
        #1;
        rst           = v.rst;
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.tgt;
        m0.imem_valid = (sel == 0) ? v.iv : 1'b0;
        m0.imem_data  = (sel == 0) ? v.idata : 16'h0000;
        m1.imem_valid = (sel == 1) ? v.iv : 1'b0;
        m1.imem_data  = (sel == 1) ? v.idata : 16'h0000;
        @(negedge clk);
        exp_v = {v.req, v.addr, v.wen, v.flush, v.hlt, v.instr, v.oldpc, v.newpc};
        act_v = (sel == 0) ? out0 : out1;
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got req/addr/wen/flush/hlt/instr/old/new=%h required %h", name, act_v, exp_v);
        end
    endtask

    vec_t tbl[25];

    initial begin
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        m0.imem_valid = 1'b0; m0.imem_data = 16'h0000;
        m1.imem_valid = 1'b0; m1.imem_data = 16'h0000;

        //              rst stl br  tgt       iv  data      req addr      wen fl  h   instr     old       new
        // reset, two in-order words
        tbl[0]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[2]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[3]  = mk(1, 0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000, 1, 0, 0, 16'h1234, 16'h0000, 16'h0002);
        tbl[4]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[5]  = mk(1, 0, 0, 16'h0000, 1, 16'h5678, 0, 16'h0000, 1, 0, 0, 16'h5678, 16'h0002, 16'h0004);
        // slow response, then stall for 3 cycles, single write on release
        tbl[6]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[7]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[8]  = mk(1, 1, 0, 16'h0000, 1, 16'hABCD, 0, 16'h0000, 0, 0, 0, 16'hABCD, 16'h0004, 16'h0006);
        tbl[9]  = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'hABCD, 16'h0004, 16'h0006);
        tbl[10] = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'hABCD, 16'h0004, 16'h0006);
        tbl[11] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'hABCD, 16'h0004, 16'h0006);
        // redirect to 0040 while 0006 outstanding; its response is dropped
        tbl[12] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[13] = mk(1, 0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[14] = mk(1, 0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[15] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[16] = mk(1, 0, 0, 16'h0000, 1, 16'h2222, 0, 16'h0000, 1, 0, 0, 16'h2222, 16'h0040, 16'h0042);
        // branch beats stall and a same-cycle response
        tbl[17] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0042, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[18] = mk(1, 1, 1, 16'h0100, 1, 16'h3333, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[19] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[20] = mk(1, 0, 0, 16'h0000, 1, 16'h4444, 0, 16'h0000, 1, 0, 0, 16'h4444, 16'h0100, 16'h0102);
        // branch in the issue cycle: request to 0102 dropped, then halt word at 0008
        tbl[21] = mk(1, 0, 1, 16'h0008, 0, 16'h0000, 1, 16'h0102, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[22] = mk(1, 0, 0, 16'h0000, 1, 16'h5555, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[23] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[24] = mk(1, 0, 0, 16'h0000, 1, 16'hF000, 0, 16'h0000, 1, 0, 0, 16'hF000, 16'h0008, 16'h000A);

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i], 0, $sformatf("vec%0d", i));
        end

        // halted: no requests, no writes for 20 cycles
        for (int i = 0; i < 20; i++) begin
            apply(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000), 0,
                  $sformatf("halt_idle%0d", i));
        end

        // wrong-path halt left by a branch to 0010
        apply(mk(1, 0, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000), 0, "halt_exit");
        apply(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), 0, "resume_req");

        // reset asserted while in HOLD
        apply(mk(1, 1, 0, 16'h0000, 1, 16'h6666, 0, 16'h0000, 0, 0, 0, 16'h6666, 16'h0010, 16'h0012), 0, "hold_enter");
        apply(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h6666, 16'h0010, 16'h0012), 0, "hold_stay");
        apply(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), 0, "rst_in_hold");
        apply(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), 0, "post_rst_req");
        apply(mk(1, 0, 0, 16'h0000, 1, 16'h7777, 0, 16'h0000, 1, 0, 0, 16'h7777, 16'h0000, 16'h0002), 0, "post_rst_word");

        // RESET_PC = FFFE: pc wraps to 0000
        apply(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), 1, "wrap_rst");
        apply(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), 1, "wrap_req");
        apply(mk(1, 0, 0, 16'h0000, 1, 16'h1357, 0, 16'h0000, 1, 0, 0, 16'h1357, 16'hFFFE, 16'h0000), 1, "wrap_word");
        apply(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), 1, "wrap_next_req");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
